branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Fetch-side branch predictor, the consumer of the EX branch resolution (taken flag).
//  IF stage: looks up if_pc in a direct-mapped BHT (2-bit counters) + BTB and returns taken/target.
//  EX stage: compares the resolved outcome with the prediction carried down the pipe.
//   On mismatch it raises redirect/flush. It then trains the tables and updates perf counters.
// PARAMETERS
//  ENTRIES  16  table depth, power of 2 (IDX_W = $clog2(ENTRIES))
//  XLEN     32  PC/target width
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     synchronous reset, active-high
//  if_pc           in   XLEN  fetch PC (bits[1:0] ignored)
//  pred_taken      out  1     IF prediction: taken
//  pred_target     out  XLEN  IF predicted target (valid when pred_taken)
//  ex_valid        in   1     EX holds a resolved control-flow instr this cycle
//  ex_pc           in   XLEN  PC of the EX instr
//  ex_is_branch    in   1     conditional branch (BEQ..BGEU)
//  ex_is_jump      in   1     JAL/JALR (always taken)
//  ex_taken        in   1     resolved taken flag from branch ALU
//  ex_target       in   XLEN  resolved target address
//  ex_pred_taken   in   1     prediction made in IF for this instr
//  ex_pred_target  in   XLEN  target predicted in IF for this instr
//  redirect_valid  out  1     mispredict: fetch must restart at redirect_pc
//  redirect_pc     out  XLEN  correct next PC
//  flush           out  1     kill IF/ID younger instrs (== redirect_valid)
//  br_count        out  32    resolved branches+jumps counted
//  mispred_count   out  32    mispredicts counted
// BEHAVIOUR
//  - index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. Entry: valid, tag, target, ctr[1:0].
//  - Lookup (comb): pred_taken = valid & tag match & ctr[1]; pred_target = entry target.
//    When not predicted taken, pred_target = 0.
//  - Resolve (comb, same cycle as ex_valid):
//    - ctl = ex_valid & (ex_is_branch | ex_is_jump); actual = ex_is_jump | ex_taken.
//    - mispred = ctl & ((actual != ex_pred_taken) | (actual & ex_target != ex_pred_target)).
//    - redirect_valid = flush = mispred; redirect_pc = actual ? ex_target : ex_pc+4.
//      Wraps modulo 2^XLEN.
//  - Train (registered, edge after ctl):
//    - branch taken: ctr sat-inc, max 2'b11.
//    - branch not-taken: ctr sat-dec, min 2'b00.
//    - jump: ctr = 2'b11.
//    - Taken (branch or jump): valid=1, tag, target = ex_target written; allocation/replacement.
//    - Not-taken on tag miss: no allocation, table unchanged.
//    - Not-taken on tag hit: only ctr decremented.
//  - New allocation sets ctr = 2'b10 (branch) or 2'b11 (jump).
//  - Same-index lookup and update in one cycle: lookup returns pre-update contents (no bypass).
//  - Perf counters (registered):
//    - br_count += ctl.
//    - mispred_count += mispred.
//    - Both saturate at 32'hFFFF_FFFF.
//  - ex_valid=0: no redirect, no training, counters hold; ex_is_* ignored.
//  - Reset:
//    - State: all valid=0, ctr=2'b01, targets/tags=0, br_count=0, mispred_count=0.
//    - Outputs while rst=1: pred_taken=0, pred_target=0, redirect_valid=0, flush=0, redirect_pc=0.
//    - Mid-operation: an EX resolution in the rst cycle is dropped (no train, no count).
//  - Latency: prediction 0 cycles; redirect 0 cycles; training visible to lookups 1 cycle later.
// TESTING
//  1 Reset: hold rst 2 cycles.
//    -> any if_pc: pred_taken=0, pred_target=0; br_count=mispred_count=0; redirect_valid=0.
//  2 Cold taken BEQ: ex_pc=0x100, taken, target 0x80, pred 0.
//    -> redirect_valid=1, redirect_pc=0x80, mispred_count=1.
//    -> Next cycle if_pc=0x100: pred_taken=1, pred_target=0x80.
//  3 Then not-taken at 0x100 with ex_pred_taken=1, ex_pred_target=0x80.
//    -> redirect_pc=0x104, flush=1; ctr 10->01; lookup 0x100 gives pred_taken=0.
//  4 Saturation: 4 taken resolutions at 0x200 (correct preds after first), then 1 not-taken.
//    -> ctr=10, still pred_taken=1; br_count=5, mispred_count=2.
//  5 Alias (ENTRIES=16): train 0x100 taken; lookup 0x140 (same index, different tag).
//    -> pred_taken=0; resolve JAL 0x140->0x300 overwrites, then 0x100 misses.
//  6 Corner cases:
//    - JAL 0x40->0x400 with ex_pred_taken=1, ex_pred_target=0x400 -> no redirect.
//    - Same-cycle lookup/update at 0x40 returns old entry.
//    - rst asserted during ex_valid -> counters stay 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped BHT (2-bit counters) plus BTB, looked up in IF,
// resolved and trained from EX, with saturating branch/mispredict performance counters.
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             ctl, actual, mispred;

    // PC word-offset bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (!rst && if_hit && ctr_q[if_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = target_q[if_idx];
        end
    end

    // Gating ctl with rst also drops any resolution arriving in a reset cycle.
    assign ctl     = ex_valid && (ex_is_branch || ex_is_jump) && !rst;
    assign actual  = ex_is_jump || ex_taken;
    assign mispred = ctl && ((actual != ex_pred_taken) ||
                             (actual && (ex_target != ex_pred_target)));

    always_comb begin
        redirect_pc = '0;
        if (!rst) begin
            redirect_pc = actual ? ex_target : ex_pc + XLEN'(4);
        end
    end

    assign redirect_valid = mispred;
    assign flush          = mispred;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (ctl) begin
            if (actual) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                if (ex_is_jump) begin
                    ctr_d[ex_idx] = 2'b11;
                end else if (ex_hit) begin
                    ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                end else begin
                    ctr_d[ex_idx] = 2'b10;
                end
            end else if (ex_hit) begin
                ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (ctl && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispred && (mispred_count_q != 32'hFFFF_FFFF)) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the table itself is reset (not just valid bits) because counters must restart at 2'b01.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by randomized
// resolutions, all compared against an entry-level reference model of the predictor tables.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_predict_unit #(.ENTRIES(16), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    longint      m_br;
    longint      m_mis;

    // Values seen at the most recent step, for directed checks against fixed numbers.
    logic        obs_rv, obs_pt;
    logic [31:0] obs_rpc, obs_ptgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
        int s;
        s     = slot(pc);
        taken = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
        tgt   = taken ? m_target[s] : 32'h0;
    endtask

    task automatic model_train(input logic [31:0] pc, input bit jp, input bit act,
                               input logic [31:0] tgt);
        int s;
        bit hit;
        s   = slot(pc);
        hit = m_valid[s] && (m_tag[s] == tag_of(pc));
        if (act) begin
            if (jp)       m_ctr[s] = 3;
            else if (hit) m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            else          m_ctr[s] = 2;
            m_valid[s]  = 1'b1;
            m_tag[s]    = tag_of(pc);
            m_target[s] = tgt;
        end else if (hit) begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
    endtask

    // One cycle: drive inputs, check combinational outputs at negedge, then the edge's effects.
    task automatic step(input bit r, input bit v, input bit br, input bit jp, input bit tk,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit ppt,
                        input logic [31:0] pptgt, input logic [31:0] ipc);
        bit          e_pt, e_ctl, e_act, e_mis;
        logic [31:0] e_ptgt, e_rpc;
        rst            = r;
        ex_valid       = v;
        ex_is_branch   = br;
        ex_is_jump     = jp;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ppt;
        ex_pred_target = pptgt;
        if_pc          = ipc;
        @(negedge clk);
        model_lookup(ipc, e_pt, e_ptgt);
        if (r) begin
            e_pt   = 1'b0;
            e_ptgt = '0;
        end
        e_ctl = !r && v && (br || jp);
        e_act = jp || tk;
        e_mis = e_ctl && ((e_act != ppt) || (e_act && (tgt != pptgt)));
        e_rpc = e_act ? tgt : pc + 32'd4;
        check("pred_taken", 32'(pred_taken), 32'(e_pt));
        check("pred_target", pred_target, e_ptgt);
        check("redirect_valid", 32'(redirect_valid), 32'(e_mis));
        check("flush", 32'(flush), 32'(e_mis));
        if (r)          check("redirect_pc_rst", redirect_pc, 32'h0);
        else if (e_mis) check("redirect_pc", redirect_pc, e_rpc);
        obs_rv   = redirect_valid;
        obs_rpc  = redirect_pc;
        obs_pt   = pred_taken;
        obs_ptgt = pred_target;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (e_ctl) begin
            model_train(pc, jp, e_act, tgt);
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (e_mis && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
        check("br_count", br_count, 32'(m_br));
        check("mispred_count", mispred_count, 32'(m_mis));
        rst      = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ipc);
    endtask

    initial begin
        logic [31:0] b0, mi0;
        model_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; if_pc = '0;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h100);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h200);
        check("rst_br_count", br_count, 32'h0);
        check("rst_mispred_count", mispred_count, 32'h0);

        // Cold taken BEQ
        step(0, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h100);
        check("t2_redirect", 32'(obs_rv), 32'h1);
        check("t2_redirect_pc", obs_rpc, 32'h80);
        check("t2_mispred_count", mispred_count, 32'h1);
        idle(32'h100);
        check("t2_pred_taken", 32'(obs_pt), 32'h1);
        check("t2_pred_target", obs_ptgt, 32'h80);

        // Not-taken after predicted taken
        step(0, 1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        check("t3_flush", 32'(obs_rv), 32'h1);
        check("t3_redirect_pc", obs_rpc, 32'h104);
        idle(32'h100);
        check("t3_pred_taken", 32'(obs_pt), 32'h0);

        // Counter saturation at 0x200
        b0  = br_count;
        mi0 = mispred_count;
        step(0, 1, 1, 0, 1, 32'h200, 32'h280, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 32'h200, 32'h280, 1, 32'h280, 32'h0);
        step(0, 1, 1, 0, 0, 32'h200, 32'h280, 1, 32'h280, 32'h0);
        idle(32'h200);
        check("t4_pred_taken", 32'(obs_pt), 32'h1);
        check("t4_br_delta", br_count - b0, 32'd5);
        check("t4_mispred_delta", mispred_count - mi0, 32'd2);

        // Aliasing on index 0
        step(0, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h0);
        idle(32'h140);
        check("t5_alias_miss", 32'(obs_pt), 32'h0);
        step(0, 1, 0, 1, 0, 32'h140, 32'h300, 0, 32'h0, 32'h0);
        idle(32'h100);
        check("t5_evicted", 32'(obs_pt), 32'h0);
        idle(32'h140);
        check("t5_new_target", obs_ptgt, 32'h300);

        // Correctly predicted JAL, with same-cycle lookup of the slot being written
        step(0, 1, 0, 1, 0, 32'h40, 32'h400, 1, 32'h400, 32'h40);
        check("t6_no_redirect", 32'(obs_rv), 32'h0);
        check("t6_old_entry", 32'(obs_pt), 32'h0);
        idle(32'h40);
        check("t6_trained", obs_ptgt, 32'h400);

        // PC+4 wraps at the top of the address space
        step(0, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 32'h0);
        check("wrap_redirect_pc", obs_rpc, 32'h0);

        // Resolution during reset is dropped
        step(1, 1, 1, 0, 1, 32'h500, 32'h600, 0, 32'h0, 32'h40);
        check("rst_ex_redirect", 32'(obs_rv), 32'h0);
        check("rst_ex_pred", 32'(obs_pt), 32'h0);
        check("rst_ex_br_count", br_count, 32'h0);
        check("rst_ex_mispred_count", mispred_count, 32'h0);

        // Randomized resolutions over a small PC pool to force hits and aliasing
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, ipc, tgt, pptgt;
            bit          r, v, br, jp, tk, ppt;
            int          kind;
            pc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            ipc  = (n % 2 == 0) ? pc
                 : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
            tgt  = 32'($urandom_range(0, 7)) << 4;
            r    = ($urandom_range(0, 63) == 0);
            v    = ($urandom_range(0, 7) != 0);
            kind = int'($urandom_range(0, 3));
            jp   = (kind == 0);
            br   = (kind == 1) || (kind == 2);
            tk   = $urandom_range(0, 1) == 1;
            model_lookup(pc, ppt, pptgt);
            if ($urandom_range(0, 3) == 0) begin
                ppt   = $urandom_range(0, 1) == 1;
                pptgt = 32'($urandom_range(0, 7)) << 4;
            end
            step(r, v, br, jp, tk, pc, tgt, ppt, pptgt, ipc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
